// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill controller.
package icache_refill_pkg;

  localparam int   AddrLen     = 32;
  localparam int   RegLen      = 32;
  localparam logic ResetEnable = 1'b1;

  localparam int   ByteW       = 8;
  localparam int   WordBytes   = RegLen / ByteW;

  typedef enum logic [1:0] {
    IcIdle   = 2'd0,
    IcFetch  = 2'd1,
    IcRefill = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_refill.sv
// IF-side fetch controller: answers hits from the cache lookup in one cycle,
// and on a miss reads the word byte-by-byte from memory, writes it into the
// cache and returns it to IF.
module icache_refill
  import icache_refill_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [AddrLen-1:0] req_addr,
  input  logic               flush,
  input  logic               hit,
  input  logic [RegLen-1:0]  hit_data,
  output logic [AddrLen-1:0] cache_addr,
  output logic               cache_replace,
  output logic [RegLen-1:0]  cache_wdata,
  output logic               resp_valid,
  output logic [RegLen-1:0]  resp_inst,
  output logic               busy,
  output logic               mem_req,
  output logic [AddrLen-1:0] mem_addr,
  input  logic               mem_grant,
  input  logic [ByteW-1:0]   mem_din
);

  ic_state_e                        state;
  logic [AddrLen-1:0]               base;
  logic [1:0]                       icnt;     // next byte to request
  logic                             idone;    // all bytes requested
  logic [1:0]                       rcnt;     // next byte lane to fill
  logic                             pend;     // a granted byte lands this cycle
  logic                             hit_vld;  // registered hit response
  logic [WordBytes-1:0][ByteW-1:0]  line_q;
  logic [WordBytes-1:0][ByteW-1:0]  word_next;
  logic                             issuing;
  logic                             granted;
  logic                             last_byte;

  assign issuing   = (state == IcFetch) && !idone;
  assign granted   = issuing && mem_grant;
  assign last_byte = pend && (rcnt == 2'd3);

  // Word as it will look once the byte arriving this cycle is dropped in.
  always_comb begin
    word_next       = line_q;
    word_next[rcnt] = mem_din;
  end

  // Lookup/write address: live PC while idle, the latched line otherwise.
  always_comb begin
    cache_addr = (state == IcIdle) ? (req_addr & ~AddrLen'(3)) : base;
  end

  assign mem_req       = issuing;
  assign mem_addr      = issuing ? (base | AddrLen'(icnt)) : '0;
  assign busy          = (state != IcIdle);
  assign cache_replace = (state == IcRefill);
  assign cache_wdata   = line_q;
  // A flush in the refill cycle still writes the (correct) word but kills the response.
  assign resp_valid    = hit_vld || ((state == IcRefill) && !flush);

  // Controller FSM: hit response, byte issue/capture counters and refill.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state     <= IcIdle;
      base      <= '0;
      icnt      <= '0;
      idone     <= 1'b0;
      rcnt      <= '0;
      pend      <= 1'b0;
      hit_vld   <= 1'b0;
      resp_inst <= '0;
      line_q    <= '0;
    end else if (flush) begin
      state   <= IcIdle;
      icnt    <= '0;
      idone   <= 1'b0;
      rcnt    <= '0;
      pend    <= 1'b0;
      hit_vld <= 1'b0;
    end else begin
      hit_vld <= 1'b0;
      case (state)
        IcIdle: begin
          if (req_valid && hit) begin
            hit_vld   <= 1'b1;
            resp_inst <= hit_data;
          end
          if (req_valid && !hit) begin
            base  <= req_addr & ~AddrLen'(3);
            icnt  <= '0;
            idone <= 1'b0;
            rcnt  <= '0;
            pend  <= 1'b0;
            state <= IcFetch;
          end
        end
        IcFetch: begin
          if (granted) begin
            icnt <= icnt + 2'd1;
            if (icnt == 2'd3) idone <= 1'b1;
          end
          pend <= granted;
          if (pend) begin
            line_q <= word_next;
            rcnt   <= rcnt + 2'd1;
          end
          if (last_byte) begin
            resp_inst <= word_next;
            state     <= IcRefill;
          end
        end
        IcRefill: begin
          state <= IcIdle;
        end
        default: begin
          state <= IcIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed scenarios with literal expectations plus
// random traffic checked every cycle against a transaction-level model.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, hit, mem_grant;
  logic [31:0] req_addr, hit_data;
  logic [31:0] cache_addr, cache_wdata, resp_inst, mem_addr;
  logic        cache_replace, resp_valid, busy, mem_req;
  logic [7:0]  mem_din = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];

  always #5 clk = ~clk;

  icache_refill dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .hit(hit), .hit_data(hit_data), .cache_addr(cache_addr),
    .cache_replace(cache_replace), .cache_wdata(cache_wdata),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_din(mem_din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian word stored in the bench memory at an aligned address.
  function automatic logic [31:0] mword(input logic [31:0] b);
    mword = {mem[b[9:0] + 10'd3], mem[b[9:0] + 10'd2], mem[b[9:0] + 10'd1], mem[b[9:0]]};
  endfunction

  // ---------------- memory responder ----------------
  logic        mem_g = 1'b0;
  logic [31:0] mem_a = 32'h0;

  always @(posedge clk) begin
    #1 mem_din = mem_g ? mem[mem_a[9:0]] : 8'($urandom);
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          chk_en = 1'b0;
  bit          m_busy, m_refill, m_hit, m_infl;
  logic [31:0] m_base, m_hdata;
  int          m_issued, m_got;

  always @(negedge clk) begin : cmp
    logic        exp_req, exp_rv;
    logic [31:0] exp_ma;
    exp_req = m_busy && !m_refill && (m_issued < 4);
    exp_ma  = exp_req ? m_base + 32'(m_issued) : 32'h0;
    exp_rv  = m_hit || (m_refill && !flush);
    if (chk_en) begin
      chk("m_busy",     {31'b0, busy},          {31'b0, m_busy});
      chk("m_mem_req",  {31'b0, mem_req},       {31'b0, exp_req});
      chk("m_mem_addr", mem_addr,               exp_ma);
      chk("m_cache_addr", cache_addr,           m_busy ? m_base : (req_addr & ~32'h3));
      chk("m_replace",  {31'b0, cache_replace}, {31'b0, m_refill});
      chk("m_resp_vld", {31'b0, resp_valid},    {31'b0, exp_rv});
      if (exp_rv)   chk("m_resp_inst", resp_inst,   m_hit ? m_hdata : mword(m_base));
      if (m_refill) chk("m_wdata",     cache_wdata, mword(m_base));
    end
    mem_g = mem_req && mem_grant;
    mem_a = mem_addr;
    // advance to the next cycle using the inputs the DUT samples at the coming edge
    if (rst || flush) begin
      m_busy = 0; m_refill = 0; m_hit = 0; m_infl = 0;
    end else if (m_refill) begin
      m_busy = 0; m_refill = 0; m_hit = 0;
    end else if (m_busy) begin
      m_hit = 0;
      if (m_infl) m_got++;
      m_infl = (m_issued < 4) && mem_grant;
      if (m_infl) m_issued++;
      if (m_got == 4) m_refill = 1;
    end else begin
      m_hit = req_valid && hit;
      if (m_hit) m_hdata = hit_data;
      if (req_valid && !hit) begin
        m_busy = 1; m_base = req_addr & ~32'h3; m_issued = 0; m_got = 0; m_infl = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [31:0] d_ma   [0:15];
  logic        d_req  [0:15];
  logic        d_busy [0:15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one miss at cycle 0, optionally stalling grants in [st0,st1] and
  // flushing at cycle fl_at; records what the DUT did on cycles 1..15.
  task automatic run_miss(input logic [31:0] a, input int st0, input int st1, input int fl_at,
                          output int rep_at, output int rv_at,
                          output logic [31:0] wd, output logic [31:0] ri);
    rep_at = -1; rv_at = -1; wd = 0; ri = 0;
    req_valid = 1; req_addr = a; hit = 0;
    for (int c = 1; c < 16; c++) begin
      step();
      req_valid = 0;
      mem_grant = !(c >= st0 && c <= st1);
      flush     = (c == fl_at);
      @(negedge clk);
      d_req[c] = mem_req; d_ma[c] = mem_addr; d_busy[c] = busy;
      if (cache_replace && rep_at < 0) begin rep_at = c; wd = cache_wdata; end
      if (resp_valid && rv_at < 0)     begin rv_at = c;  ri = resp_inst;   end
    end
    step();
    flush = 0; mem_grant = 1;
  endtask

  initial begin : main
    int rep, rv;
    logic [31:0] wd, ri;
    rst = 1; req_valid = 0; req_addr = 0; flush = 0; hit = 0; hit_data = 0; mem_grant = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h100] = 8'h93; mem[10'h101] = 8'h00; mem[10'h102] = 8'hA0; mem[10'h103] = 8'h00;
    mem[10'h200] = 8'h13; mem[10'h201] = 8'h05; mem[10'h202] = 8'h10; mem[10'h203] = 8'h00;
    repeat (3) step();
    chk_en = 1;
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid},    32'h0);
    chk("rst_resp_inst",  resp_inst,              32'h0);
    chk("rst_replace",    {31'b0, cache_replace}, 32'h0);
    chk("rst_wdata",      cache_wdata,            32'h0);
    chk("rst_mem_req",    {31'b0, mem_req},       32'h0);
    chk("rst_mem_addr",   mem_addr,               32'h0);
    chk("rst_busy",       {31'b0, busy},          32'h0);
    step();
    rst = 0;
    step();

    // hit: one-cycle response, aligned lookup address
    req_valid = 1; req_addr = 32'h0000_1006; hit = 1; hit_data = 32'h00A0_0093;
    @(negedge clk);
    chk("hit_cache_addr", cache_addr, 32'h0000_1004);
    step();
    req_valid = 0; hit = 0; hit_data = 0;
    @(negedge clk);
    chk("hit_resp_valid", {31'b0, resp_valid}, 32'h1);
    chk("hit_resp_inst",  resp_inst,           32'h00A0_0093);
    step();

    // plain miss
    run_miss(32'h100, 0, 0, 0, rep, rv, wd, ri);
    for (int c = 1; c <= 4; c++) begin
      chk("miss_mem_req",  {31'b0, d_req[c]}, 32'h1);
      chk("miss_mem_addr", d_ma[c],           32'h100 + 32'(c - 1));
    end
    chk("miss_req_off",   {31'b0, d_req[5]}, 32'h0);
    chk("miss_rep_cycle", rep,               32'd6);
    chk("miss_rv_cycle",  rv,                32'd6);
    chk("miss_wdata",     wd,                32'h00A0_0093);
    chk("miss_inst",      ri,                32'h00A0_0093);
    chk("miss_idle_t7",   {31'b0, d_busy[7]}, 32'h0);

    // grant stall on cycles 2 and 3
    run_miss(32'h100, 2, 3, 0, rep, rv, wd, ri);
    chk("stall_addr2",     d_ma[2], 32'h101);
    chk("stall_addr3",     d_ma[3], 32'h101);
    chk("stall_addr4",     d_ma[4], 32'h101);
    chk("stall_addr5",     d_ma[5], 32'h102);
    chk("stall_rep_cycle", rep,     32'd8);
    chk("stall_wdata",     wd,      32'h00A0_0093);

    // flush during FETCH, then a fresh miss elsewhere
    run_miss(32'h100, 0, 0, 3, rep, rv, wd, ri);
    chk("flf_no_replace", rep,                32'hFFFF_FFFF);
    chk("flf_no_resp",    rv,                 32'hFFFF_FFFF);
    chk("flf_idle_t4",    {31'b0, d_busy[4]}, 32'h0);
    run_miss(32'h200, 0, 0, 0, rep, rv, wd, ri);
    chk("flf_next_addr",  d_ma[1], 32'h200);
    chk("flf_next_rep",   rep,     32'd6);
    chk("flf_next_inst",  ri,      32'h0010_0513);

    // flush during REFILL: write still happens, response suppressed
    run_miss(32'h100, 0, 0, 6, rep, rv, wd, ri);
    chk("flr_replace", rep, 32'd6);
    chk("flr_wdata",   wd,  32'h00A0_0093);
    chk("flr_no_resp", rv,  32'hFFFF_FFFF);
    req_valid = 1; req_addr = 32'h100; hit = 1; hit_data = 32'h00A0_0093;
    step();
    req_valid = 0; hit = 0;
    @(negedge clk);
    chk("flr_hit_valid", {31'b0, resp_valid}, 32'h1);
    chk("flr_hit_inst",  resp_inst,           32'h00A0_0093);
    step();

    // reset held three cycles in the middle of a fetch
    req_valid = 1; req_addr = 32'h300; hit = 0;
    step();
    req_valid = 0; req_addr = 0;
    step();
    rst = 1;
    step();
    @(negedge clk);
    chk("rmid_busy",     {31'b0, busy},          32'h0);
    chk("rmid_mem_req",  {31'b0, mem_req},       32'h0);
    chk("rmid_mem_addr", mem_addr,               32'h0);
    chk("rmid_replace",  {31'b0, cache_replace}, 32'h0);
    chk("rmid_resp",     {31'b0, resp_valid},    32'h0);
    chk("rmid_inst",     resp_inst,              32'h0);
    chk("rmid_wdata",    cache_wdata,            32'h0);
    chk("rmid_caddr",    cache_addr,             32'h0);
    step(); step();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      @(negedge clk);
      chk("rpost_busy",    {31'b0, busy},          32'h0);
      chk("rpost_replace", {31'b0, cache_replace}, 32'h0);
    end

    // random traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!req_valid || $urandom_range(0, 3) == 0) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_addr  = 32'($urandom_range(0, 1023));
        hit       = $urandom_range(0, 1) == 1;
      end
      hit_data  = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      mem_grant = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    step();
    rst = 0; flush = 0; req_valid = 0; mem_grant = 1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
